// File: rtl/fifo_flex.sv
// Parametrised synchronous FIFO with standard or first-word-fall-through read,
// programmable almost thresholds, occupancy count and sticky error flags.
module fifo_flex #(
    parameter  int WIDTH         = 8,
    parameter  int DEPTH         = 4,
    parameter  int FWFT          = 0,
    parameter  int AFULL_THRESH  = DEPTH - 1,
    parameter  int AEMPTY_THRESH = 1,
    localparam int PTRWIDTH      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                wr_en,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                rd_en,
    output logic [WIDTH-1:0]    rd_data,
    output logic                rd_valid,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [PTRWIDTH:0]   count,
    output logic                overflow,
    output logic                underflow,
    input  logic                clr_err
);

    localparam int CW = PTRWIDTH + 1;
    localparam logic [PTRWIDTH:0] AF_T    = CW'(AFULL_THRESH);
    localparam logic [PTRWIDTH:0] AE_T    = CW'(AEMPTY_THRESH);
    localparam logic [PTRWIDTH:0] PTR_ONE = CW'(1);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTRWIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTRWIDTH-1:0] wr_idx, rd_idx;
    logic                ovf_q, ovf_d, udf_q, udf_d;
    logic                rd_acc, wr_acc;

    assign wr_idx       = wr_ptr_q[PTRWIDTH-1:0];
    assign rd_idx       = rd_ptr_q[PTRWIDTH-1:0];
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[PTRWIDTH] != rd_ptr_q[PTRWIDTH]) && (wr_idx == rd_idx);
    assign count        = wr_ptr_q - rd_ptr_q;
    assign almost_full  = (count >= AF_T);
    assign almost_empty = (count <= AE_T);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // A write while full is still accepted when a read frees the head slot.
    always_comb begin
        rd_acc   = rd_en && !empty;
        wr_acc   = wr_en && (!full || rd_en);
        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        ovf_d    = (wr_en && !wr_acc) || (ovf_q && !clr_err);
        udf_d    = (rd_en && empty)   || (udf_q && !clr_err);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_idx] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = empty ? '0 : mem_q[rd_idx];
            assign rd_valid = !empty;
        end else begin : g_std
            logic [WIDTH-1:0] rd_data_q;
            logic             rd_valid_q;
            // Sampling the head with NBA gives read-before-write on write-through.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem_q[rd_idx];
                end
            end
            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_flex.sv
// Scoreboard bench for fifo_flex: one standard-mode and one FWFT instance,
// directed stimulus with expected read data queued and checked by monitors.
module tb_fifo_flex;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // standard-mode instance (suffix 0) and FWFT instance (suffix 1)
    logic       w0 = 0, r0 = 0, c0 = 0, w1 = 0, r1 = 0, c1 = 0;
    logic [7:0] wd0 = 0, wd1 = 0, rd0, rd1;
    logic       rv0, fu0, em0, af0, ae0, ov0, un0;
    logic       rv1, fu1, em1, af1, ae1, ov1, un1;
    logic [2:0] cn0, cn1;

    int errors = 0;
    int checks = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    fifo_flex #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u0 (
        .clk(clk), .rstn(rstn), .wr_en(w0), .wr_data(wd0), .rd_en(r0),
        .rd_data(rd0), .rd_valid(rv0), .full(fu0), .empty(em0),
        .almost_full(af0), .almost_empty(ae0), .count(cn0),
        .overflow(ov0), .underflow(un0), .clr_err(c0));

    fifo_flex #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u1 (
        .clk(clk), .rstn(rstn), .wr_en(w1), .wr_data(wd1), .rd_en(r1),
        .rd_data(rd1), .rd_valid(rv1), .full(fu1), .empty(em1),
        .almost_full(af1), .almost_empty(ae1), .count(cn1),
        .overflow(ov1), .underflow(un1), .clr_err(c1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Standard mode: every rd_valid cycle must match the next queued word.
    always @(negedge clk) begin
        if (rstn && rv0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL rv0_spurious: got rd_valid=1 data=%0h expected no word", rd0);
            end else begin
                logic [7:0] e;
                e = q0.pop_front();
                if (rd0 !== e) begin
                    errors++;
                    $display("FAIL rd0_data: got %0h expected %0h at %0t", rd0, e, $time);
                end
            end
        end
    end

    // FWFT: the word presented during a pop cycle must match the queue head.
    always @(negedge clk) begin
        if (rstn && rv1 && r1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL rv1_spurious: got pop of %0h expected no word", rd1);
            end else begin
                logic [7:0] e;
                e = q1.pop_front();
                if (rd1 !== e) begin
                    errors++;
                    $display("FAIL rd1_data: got %0h expected %0h at %0t", rd1, e, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] a0 [4];
        a0[0] = 8'h11; a0[1] = 8'h22; a0[2] = 8'h33; a0[3] = 8'h44;

        // reset state
        step(); step();
        chk("rst_empty", em0, 1); chk("rst_full", fu0, 0); chk("rst_count", cn0, 0);
        chk("rst_ae", ae0, 1); chk("rst_af", af0, 0); chk("rst_rv", rv0, 0);
        chk("rst_rd", rd0, 0); chk("rst_ov", ov0, 0); chk("rst_un", un0, 0);
        chk("rst_rv1", rv1, 0); chk("rst_rd1", rd1, 0);
        rstn = 1'b1;
        step();

        // fill to full, with one rejected write
        w0 = 1;
        for (int i = 0; i < 4; i++) begin
            wd0 = a0[i];
            step();
            if (i == 0) chk("cnt1_ae", ae0, 1);
            if (i == 1) begin chk("cnt2_ae", ae0, 0); chk("cnt2_af", af0, 0); end
            if (i == 2) begin chk("cnt3_af", af0, 1); chk("cnt3_full", fu0, 0); end
        end
        chk("full4", fu0, 1); chk("count4", cn0, 4); chk("ov_before", ov0, 0);
        wd0 = 8'h55; step(); w0 = 0;
        chk("ov_set", ov0, 1); chk("count_after_ovf", cn0, 4);
        r0 = 1;
        for (int i = 0; i < 4; i++) begin q0.push_back(a0[i]); step(); end
        r0 = 0; step();
        chk("drain_empty", em0, 1); chk("drain_rv", rv0, 0); chk("rd_hold", rd0, 8'h44);
        c0 = 1; step(); c0 = 0;
        chk("ov_clr", ov0, 0);

        // write-through when full
        w0 = 1;
        for (int i = 0; i < 4; i++) begin wd0 = 8'hA0 + 8'(i); step(); end
        wd0 = 8'hB0; r0 = 1; q0.push_back(8'hA0); step();
        w0 = 0;
        chk("wt_count", cn0, 4); chk("wt_full", fu0, 1); chk("wt_ov", ov0, 0);
        q0.push_back(8'hA1); step();
        q0.push_back(8'hA2); step();
        q0.push_back(8'hA3); step();
        q0.push_back(8'hB0); step();
        r0 = 0; step();
        chk("wt_empty", em0, 1);

        // underflow, clear races
        r0 = 1; step();
        chk("un_set", un0, 1); chk("un_count", cn0, 0); chk("un_empty", em0, 1);
        c0 = 1; step();
        chk("un_set_wins", un0, 1);
        r0 = 0; step(); c0 = 0;
        chk("un_clr", un0, 0);
        w0 = 1; r0 = 1; wd0 = 8'h77; step();
        w0 = 0; r0 = 0;
        chk("empty_wr_rd_count", cn0, 1); chk("empty_wr_rd_un", un0, 1);
        c0 = 1; r0 = 1; q0.push_back(8'h77); step();
        c0 = 0; r0 = 0; step();
        chk("un_clr2", un0, 0); chk("empty2", em0, 1);

        // wrap: 10 write/read pairs
        for (int i = 0; i < 10; i++) begin
            w0 = 1; wd0 = 8'hC0 + 8'(i); step();
            w0 = 0; r0 = 1; q0.push_back(8'hC0 + 8'(i)); step();
            r0 = 0;
        end
        step();
        chk("wrap_empty", em0, 1);

        // FWFT instance
        w1 = 1; wd1 = 8'h5A; step(); w1 = 0;
        chk("fw_rv", rv1, 1); chk("fw_rd", rd1, 8'h5A); chk("fw_cnt", cn1, 1);
        r1 = 1; q1.push_back(8'h5A); step(); r1 = 0;
        chk("fw_pop_rv", rv1, 0); chk("fw_pop_rd", rd1, 0); chk("fw_pop_empty", em1, 1);
        w1 = 1;
        for (int i = 1; i <= 3; i++) begin wd1 = 8'(i); step(); end
        w1 = 0; r1 = 1;
        for (int i = 1; i <= 3; i++) begin q1.push_back(8'(i)); step(); end
        r1 = 1; step(); r1 = 0;
        chk("fw_un", un1, 1); chk("fw_empty", em1, 1);

        // asynchronous reset mid-burst with count = 2
        w0 = 1; wd0 = 8'hE1; step();
        wd0 = 8'hE2; step();
        wd0 = 8'hE3; r0 = 1; q0.push_back(8'hE1); step();
        chk("pre_rst_count", cn0, 2);
        w1 = 1; wd1 = 8'h99; step(); w1 = 0;
        // the E2 read on u0 completed above; reset between edges after the monitor
        r0 = 0; w0 = 0;
        q0.push_back(8'hE2);
        @(negedge clk); #1;
        rstn = 1'b0; #1;
        chk("arst_count", cn0, 0); chk("arst_empty", em0, 1); chk("arst_rv", rv0, 0);
        chk("arst_rd", rd0, 0); chk("arst_un1", un1, 0); chk("arst_empty1", em1, 1);
        step(); rstn = 1'b1; step();

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
Parametrised synchronous FIFO, the next generation of the team's basic FIFO. Adds:
- selectable standard or first-word-fall-through (FWFT) read mode
- programmable almost-full and almost-empty thresholds
- occupancy count
- sticky overflow and underflow error flags
- write-through-when-full on a simultaneous read

Used as the general buffering primitive between streaming stages within one clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, number of entries; power of two, >=2
FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency), 1 = first-word-fall-through
AFULL_THRESH, DEPTH-1, almost_full asserts when count >= this value (1..DEPTH)
AEMPTY_THRESH, 1, almost_empty asserts when count <= this value (0..DEPTH-1)
PTRWIDTH (localparam), $clog2(DEPTH), pointer index width; pointers carry one extra wrap bit

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
wr_en  input  1  write request
wr_data  input  WIDTH  write data
rd_en  input  1  read/pop request
rd_data  output  WIDTH  read data
rd_valid  output  1  rd_data holds a valid word (see Behaviour)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  PTRWIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected
clr_err  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rstn low, asynchronous, any time including mid-transfer):
  - wr_ptr, rd_ptr and count clear to 0.
  - rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Memory contents are not cleared.
  - After reset: empty = 1, full = 0, almost_empty = 1, almost_full = 0 (given legal thresholds).
- Accept rules are evaluated on the state before the edge:
  - rd_acc = rd_en && !empty
  - wr_acc = wr_en && (!full || rd_en)
  - When full with a simultaneous rd_en, both are accepted and count is unchanged.
  - When empty with a simultaneous wr_en and rd_en, only the write is accepted and underflow sets.
- Pointers:
  - wr_ptr / rd_ptr are PTRWIDTH+1 bits wide and increment by 1 on accept, wrapping naturally.
  - The memory index is ptr[PTRWIDTH-1:0].
  - full = MSBs differ and indices equal; empty = pointers equal.
- count = wr_ptr - rd_ptr (modulo 2^(PTRWIDTH+1)).
  - count, full, empty, almost_full and almost_empty are all derived from registered pointers.
  - They update the cycle after an accept, with no combinational path from wr_en/rd_en.
- FWFT=0 (standard mode):
  - On rd_acc, rd_data is loaded from the head at the edge; rd_valid = 1 for exactly that following cycle.
  - Otherwise rd_valid = 0 and rd_data holds its last value.
  - Latency is 1 cycle from rd_en to data.
- FWFT=1 (first-word-fall-through mode):
  - rd_data = mem[rd_ptr index] and rd_valid = !empty, combinationally from the registered pointer.
  - rd_data = 0 when empty.
  - rd_en acts as a pop/acknowledge; the next word appears the cycle after the pop.
  - A word written into an empty FIFO appears on rd_data the cycle after the write.
- Error flags:
  - overflow sets on wr_en && !wr_acc; underflow sets on rd_en && empty.
  - Both hold until clr_err = 1 at an edge.
  - If a new error and clr_err occur in the same cycle, the set wins.
  - Rejected operations never modify pointers or memory.
- Read-during-write to the same index cannot occur except through write-through when full. In that case the read returns the old head (read-before-write).

Test Plan:
- Reset then idle (WIDTH=8, DEPTH=4) -> empty=1, full=0, count=0, almost_empty=1, rd_valid=0, rd_data=0, overflow=underflow=0.
- FWFT=0: write 0x11,0x22,0x33,0x44; fifth write 0x55 -> full=1, count=4, almost_full=1 at count 3, overflow=1; read 4 times -> rd_data 0x11,0x22,0x33,0x44 each 1 cycle after rd_en with rd_valid=1; then empty=1.
- Full FIFO (0xA0..0xA3), wr_en and rd_en together with wr_data 0xB0 -> rd_data=0xA0, count stays 4, overflow stays 0; drain -> 0xA1,0xA2,0xA3,0xB0.
- FWFT=1: write 0x5A to empty -> next cycle rd_valid=1, rd_data=0x5A with no rd_en; pop -> rd_valid=0, rd_data=0, empty=1.
- Empty FIFO with rd_en=1 -> underflow=1, pointers unchanged; clr_err together with another rd_en on the empty FIFO -> underflow stays 1; clr_err alone -> underflow=0.
- Wrap and reset: 10 interleaved write/read pairs (pointers wrap twice), data matches in order; assert rstn low mid-burst with count=2 -> count=0, empty=1 immediately (asynchronous), rd_valid=0.
